uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Byte buffer and launcher that sits directly upstream of the UART top-level transmit port.
- Producers (CPU bus, command logic) push bytes at any rate. The block queues them and issues them one at a time on the transmitter's data/valid/busy interface.
- Only one byte is outstanding at a time. A byte leaves the queue only after the transmitter has visibly accepted it.

Parameters:
- DEPTH, 16, number of byte entries. Must be a power of two, minimum 2.
- ADDR_W, $clog2(DEPTH), pointer width. Derived; do not override.
- ACK_TIMEOUT, 8, cycles to wait for the transmitter's busy to rise after a launch before re-launching the same byte.

Ports:
- clk  in  1  system clock. Single clock domain.
- rst  in  1  synchronous, active-high reset.
- in_wr_data  in  8  byte to enqueue.
- in_wr_en  in  1  enqueue strobe, sampled each rising edge.
- out_full  out  1  queue holds DEPTH bytes.
- out_empty  out  1  queue holds 0 bytes.
- out_level  out  ADDR_W+1  current byte count, 0..DEPTH.
- out_overflow  out  1  sticky flag: a write was dropped because the queue was full.
- in_ovf_clear  in  1  clears out_overflow on its rising edge.
- out_tx_data  out  8  byte presented to the transmitter.
- out_tx_valid  out  1  one-cycle launch request to the transmitter.
- in_tx_busy  in  1  transmitter busy/acknowledge.

Behaviour:
- Reset values (synchronous rst=1):
  - pointers = 0, out_level = 0, out_empty = 1, out_full = 0.
  - out_overflow = 0, out_tx_valid = 0, out_tx_data = 8'h00.
  - FSM = IDLE; timeout counter = 0.
  - Queue contents are not cleared.
- rst asserted mid-transfer: the FSM returns to IDLE and the in-flight byte is discarded.
- Write: when in_wr_en=1 and the queue is not full, store at wr_ptr, then wr_ptr+1 modulo DEPTH.
- Dropped write: when in_wr_en=1 and the queue is full, the data is dropped and out_overflow is set in the same edge.
  - Exception: if a pop occurs on that edge, the write is accepted and overflow is not set.
- Pop: rd_ptr+1 modulo DEPTH. Occurs only on the WAIT_BUSY to WAIT_DONE transition.
- Level update per edge: out_level = out_level + write_accepted - pop. A simultaneous write and pop leaves the level unchanged.
- Flags: out_full and out_empty are derived from out_level and registered with it.
- Overflow clear: an in_ovf_clear rising edge, detected against a registered copy of in_ovf_clear, clears out_overflow.
  - A clear and a new drop on the same edge leave out_overflow = 1.
- FSM (enum in package):
  - IDLE: if !out_empty and !in_tx_busy, load out_tx_data <= mem[rd_ptr] and go to LAUNCH. Otherwise stay.
  - LAUNCH: out_tx_valid=1 for exactly this one cycle. Clear the timeout counter. Go to WAIT_BUSY.
  - WAIT_BUSY: out_tx_valid=0.
    - If in_tx_busy=1: pop, go to WAIT_DONE.
    - Else if counter == ACK_TIMEOUT-1: go to LAUNCH, re-issuing the same byte without popping.
    - Else increment the counter.
  - WAIT_DONE: when in_tx_busy=0, go to IDLE.
- out_tx_data is stable from the IDLE to LAUNCH edge until the FSM next leaves IDLE.
- Latency: a write into an empty queue while the transmitter is idle, accepted at edge E, gives out_tx_valid=1 during the cycle after edge E+2.
- Minimum turnaround between consecutive launches: LAUNCH, WAIT_BUSY (≥1), WAIT_DONE (≥1), IDLE, i.e. 4 cycles plus the transmitter's busy time.
- in_tx_busy already high in IDLE (foreign transfer): no launch until it falls.
- The counter width holds ACK_TIMEOUT-1. No arithmetic may wrap beyond DEPTH.

Decomposition:
- Package uart_pkg holds:
  - typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} tx_fifo_state_t.
  - localparam UART_BYTE_W = 8.
  - Shared with later RX-side blocks.
- One sub-module, sync_fifo_mem: a DEPTH×8 register array with one write port and an asynchronous read at rd_ptr.
- Pointers, level, flags and the FSM stay in uart_tx_fifo.

Test Plan:
- Reset then idle: after rst, out_empty=1, out_level=0, and out_tx_valid stays 0 for 50 cycles with in_tx_busy=0.
- Single byte: write 8'hA5 at edge E; the transmitter model raises busy 1 cycle after valid and holds it 20 cycles.
  - Required: out_tx_valid pulses exactly once with out_tx_data=8'hA5.
  - Required: out_level goes 1 to 0 on busy rise, and the FSM is back in IDLE 1 cycle after busy falls.
- Burst and order: write 0x01..0x10 (DEPTH=16) back-to-back. out_full=1 after the 16th write, and transmitted order is 0x01..0x10 exactly.
- Overflow: with in_tx_busy held 1, write 17 bytes.
  - Required: out_level=16, out_overflow=1, and the 17th byte is never transmitted.
  - A pulse on in_ovf_clear returns out_overflow to 0.
- Timeout retry: the transmitter model ignores the first launch of 8'h3C.
  - Required: a second out_tx_valid pulse exactly 9 cycles after the first (LAUNCH plus 8 WAIT_BUSY), with the same data 8'h3C.
  - Required: out_level unchanged until busy rises.
- Full plus simultaneous pop: queue full, and the write coincides with the busy-rise edge. The write is accepted, out_level stays 16, and out_overflow stays 0.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: types and constants shared by the UART transmit-side and receive-side blocks.
//   UART_BYTE_W     : width of one UART data byte
//   tx_fifo_state_t : launcher FSM states of uart_tx_fifo
package uart_pkg;

    localparam int unsigned UART_BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE
    } tx_fifo_state_t;

endpackage

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: DEPTH x byte storage array, one synchronous write port and one
// asynchronous read port. Contents are never reset.
//   clk       : system clock
//   wr_en     : write strobe
//   wr_addr   : write address
//   wr_data   : byte written at wr_addr
//   rd_addr   : read address
//   rd_data_c : byte stored at rd_addr (combinational)
module sync_fifo_mem
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [UART_BYTE_W-1:0] wr_data,
    input  logic [ADDR_W-1:0]      rd_addr,
    output logic [UART_BYTE_W-1:0] rd_data_c
);

    logic [UART_BYTE_W-1:0] mem [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Asynchronous read
    assign rd_data_c = mem[rd_addr];

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte queue that feeds the UART transmitter one byte at a time.
// A byte is removed from the queue only once the transmitter raises busy after a
// launch; if busy does not rise within ACK_TIMEOUT cycles the same byte is re-launched.
//   clk, rst       : clock, synchronous active-high reset
//   in_wr_data     : byte to enqueue
//   in_wr_en       : enqueue strobe
//   out_full       : queue holds DEPTH bytes
//   out_empty      : queue holds no bytes
//   out_level      : byte count 0..DEPTH
//   out_overflow   : sticky, a write was dropped on a full queue
//   in_ovf_clear   : rising edge clears out_overflow
//   out_tx_data    : byte presented to the transmitter
//   out_tx_valid   : one-cycle launch request
//   in_tx_busy     : transmitter busy / acknowledge
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned ADDR_W      = $clog2(DEPTH),
    parameter int unsigned ACK_TIMEOUT = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [UART_BYTE_W-1:0] in_wr_data,
    input  logic                   in_wr_en,
    output logic                   out_full,
    output logic                   out_empty,
    output logic [ADDR_W:0]        out_level,
    output logic                   out_overflow,
    input  logic                   in_ovf_clear,
    output logic [UART_BYTE_W-1:0] out_tx_data,
    output logic                   out_tx_valid,
    input  logic                   in_tx_busy
);

    localparam int unsigned LVL_W = ADDR_W + 1;
    localparam int unsigned CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    tx_fifo_state_t state;
    tx_fifo_state_t state_next;

    logic [ADDR_W-1:0]      wr_ptr;
    logic [ADDR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]       cnt;
    logic                   ovf_clear_q;
    logic [UART_BYTE_W-1:0] rd_byte_c;
    logic [LVL_W-1:0]       level_next_c;

    logic pop_c;
    logic load_c;
    logic cnt_clr_c;
    logic cnt_inc_c;
    logic valid_next_c;
    logic timeout_c;
    logic wr_accept_c;
    logic drop_c;
    logic clr_rise_c;

    sync_fifo_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk       (clk),
        .wr_en     (wr_accept_c & ~rst),
        .wr_addr   (wr_ptr),
        .wr_data   (in_wr_data),
        .rd_addr   (rd_ptr),
        .rd_data_c (rd_byte_c)
    );

    assign timeout_c = (cnt == CNT_W'(ACK_TIMEOUT - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (!out_empty && !in_tx_busy) begin
                    state_next = LAUNCH;
                end
            end
            LAUNCH: begin
                state_next = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (in_tx_busy) begin
                    state_next = WAIT_DONE;
                end else if (timeout_c) begin
                    state_next = LAUNCH;
                end
            end
            WAIT_DONE: begin
                if (!in_tx_busy) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM control outputs
    always_comb begin
        pop_c        = 1'b0;
        load_c       = 1'b0;
        cnt_clr_c    = 1'b0;
        cnt_inc_c    = 1'b0;
        valid_next_c = 1'b0;
        case (state)
            IDLE: begin
                load_c = !out_empty && !in_tx_busy;
            end
            LAUNCH: begin
                cnt_clr_c    = 1'b1;
                valid_next_c = 1'b1;
            end
            WAIT_BUSY: begin
                pop_c     = in_tx_busy;
                cnt_inc_c = !in_tx_busy && !timeout_c;
            end
            default: ;
        endcase
    end

    // A pop on the same edge frees a slot, so a write into a full queue still lands.
    assign wr_accept_c  = in_wr_en & (~out_full | pop_c);
    assign drop_c       = in_wr_en & out_full & ~pop_c;
    assign clr_rise_c   = in_ovf_clear & ~ovf_clear_q;
    assign level_next_c = out_level + LVL_W'(wr_accept_c) - LVL_W'(pop_c);

    // Registered copy of the clear input for edge detection
    always_ff @(posedge clk) begin
        ovf_clear_q <= in_ovf_clear;
    end

    // Pointers, level, flags, timeout counter and transmitter outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            out_level    <= '0;
            out_empty    <= 1'b1;
            out_full     <= 1'b0;
            out_overflow <= 1'b0;
            out_tx_valid <= 1'b0;
            out_tx_data  <= '0;
            cnt          <= '0;
        end else begin
            if (wr_accept_c) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            out_level <= level_next_c;
            out_full  <= (level_next_c == LVL_W'(DEPTH));
            out_empty <= (level_next_c == '0);

            // A new drop wins over a simultaneous clear
            if (drop_c) begin
                out_overflow <= 1'b1;
            end else if (clr_rise_c) begin
                out_overflow <= 1'b0;
            end

            // Valid is registered from LAUNCH, so it appears the cycle after the FSM enters LAUNCH
            out_tx_valid <= valid_next_c;
            if (load_c) begin
                out_tx_data <= rd_byte_c;
            end

            if (cnt_clr_c) begin
                cnt <= '0;
            end else if (cnt_inc_c) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed and random stimulus for uart_tx_fifo, checked every cycle
// against a queue-based reference model and a simple transmitter model.
module tb_uart_tx_fifo;
    import uart_pkg::*;

    localparam int unsigned DEPTH       = 16;
    localparam int unsigned ADDR_W      = 4;
    localparam int unsigned ACK_TIMEOUT = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [7:0]        wr_data;
    logic              wr_en;
    logic              ovf_clear;
    logic              tx_busy;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   level;
    logic              overflow;
    logic [7:0]        tx_data;
    logic              tx_valid;

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .DEPTH       (DEPTH),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_wr_data   (wr_data),
        .in_wr_en     (wr_en),
        .out_full     (full),
        .out_empty    (empty),
        .out_level    (level),
        .out_overflow (overflow),
        .in_ovf_clear (ovf_clear),
        .out_tx_data  (tx_data),
        .out_tx_valid (tx_valid),
        .in_tx_busy   (tx_busy)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int cycle    = 0;

    // Reference model state
    logic [7:0] mq[$];
    logic       m_ovf     = 1'b0;
    logic       clr_prev  = 1'b0;
    bit         waiting   = 1'b0;

    // Transmitter model state and observation log
    bit         ignore_next  = 1'b0;
    bit         rise_pending = 1'b0;
    bit         xfer_active  = 1'b0;
    int         busy_left    = 0;
    int         hold_len     = 20;
    logic [7:0] sent[$];
    logic [7:0] exp_q[$];
    int         valid_cnt        = 0;
    int         last_valid_cycle = 0;
    int         prev_valid_cycle = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: update the model for the edge, check outputs, run the transmitter model.
    task automatic step();
        bit pop_m, acc_m, drop_m, rise_m;
        @(posedge clk);
        cycle++;
        if (rst) begin
            mq.delete();
            m_ovf   = 1'b0;
            waiting = 1'b0;
        end else begin
            pop_m  = waiting && tx_busy;
            acc_m  = wr_en && ((mq.size() < DEPTH) || pop_m);
            drop_m = wr_en && !acc_m;
            rise_m = ovf_clear && !clr_prev;
            if (pop_m) begin
                void'(mq.pop_front());
                waiting = 1'b0;
            end
            if (acc_m) mq.push_back(wr_data);
            if (drop_m) m_ovf = 1'b1;
            else if (rise_m) m_ovf = 1'b0;
        end
        clr_prev = ovf_clear;
        #1;
        check("level",    32'(level),    32'(mq.size()));
        check("empty",    32'(empty),    32'(mq.size() == 0));
        check("full",     32'(full),     32'(mq.size() == DEPTH));
        check("overflow", 32'(overflow), 32'(m_ovf));

        if (rst) begin
            rise_pending = 1'b0;
            xfer_active  = 1'b0;
            tx_busy      = 1'b0;
        end else if (xfer_active) begin
            busy_left--;
            if (busy_left <= 0) begin
                xfer_active = 1'b0;
                tx_busy     = 1'b0;
            end
        end else if (rise_pending) begin
            rise_pending = 1'b0;
            xfer_active  = 1'b1;
            busy_left    = hold_len;
            tx_busy      = 1'b1;
        end

        if (tx_valid) begin
            valid_cnt++;
            prev_valid_cycle = last_valid_cycle;
            last_valid_cycle = cycle;
            if (mq.size() == 0) check("valid_on_empty", 32'(tx_valid), 32'(0));
            else check("tx_data", 32'(tx_data), 32'(mq[0]));
            sent.push_back(tx_data);
            waiting = 1'b1;
            if (ignore_next) ignore_next = 1'b0;
            else rise_pending = 1'b1;
        end
    endtask

    task automatic drain(input string tag);
        bit done = 1'b0;
        for (int i = 0; i < 2000 && !done; i++) begin
            step();
            done = (mq.size() == 0) && !xfer_active && !rise_pending && !waiting && !tx_busy;
        end
        check({tag, "_drain_done"}, 32'(done), 32'(1));
        step();
        step();
    endtask

    task automatic compare_sent(input string tag);
        check({tag, "_count"}, 32'(sent.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < sent.size(); i++) begin
            check({tag, "_byte"}, 32'(sent[i]), 32'(exp_q[i]));
        end
    endtask

    task automatic write_byte(input logic [7:0] b);
        wr_data = b;
        wr_en   = 1'b1;
        step();
        wr_en   = 1'b0;
    endtask

    initial begin
        int  v0;
        bit  got;
        logic [7:0] b;

        rst = 1'b1; wr_data = '0; wr_en = 1'b0; ovf_clear = 1'b0; tx_busy = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Reset state and idle behaviour
        check("rst_tx_data",  32'(tx_data),  32'(0));
        check("rst_tx_valid", 32'(tx_valid), 32'(0));
        check("rst_level",    32'(level),    32'(0));
        check("rst_empty",    32'(empty),    32'(1));
        for (int i = 0; i < 50; i++) begin
            step();
            check("idle_valid", 32'(tx_valid), 32'(0));
        end

        // Single byte: latency, one pulse, return to IDLE after busy falls
        hold_len = 20;
        sent.delete();
        v0 = valid_cnt;
        write_byte(8'hA5);
        step();
        check("lat_e1_valid", 32'(tx_valid), 32'(0));
        step();
        check("lat_e2_valid", 32'(tx_valid), 32'(1));
        check("lat_e2_data",  32'(tx_data),  32'(8'hA5));
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            step();
            got = tx_busy;
        end
        check("single_busy_rose", 32'(got), 32'(1));
        for (int i = 0; i < 40 && tx_busy; i++) step();
        check("single_busy_fell", 32'(tx_busy), 32'(0));
        step();
        check("single_state_idle", 32'(dut.state), 32'(IDLE));
        check("single_pulses", 32'(valid_cnt - v0), 32'(1));
        exp_q = '{8'hA5};
        compare_sent("single");

        // Burst and order, transmitter held busy so the queue fills
        hold_len = int'($urandom_range(1, 4));
        sent.delete();
        exp_q.delete();
        tx_busy = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            write_byte(8'(i));
            exp_q.push_back(8'(i));
        end
        check("burst_full", 32'(full), 32'(1));
        tx_busy = 1'b0;
        drain("burst");
        compare_sent("burst");

        // Overflow: 17 writes while busy, clear-vs-drop priority, then clear
        sent.delete();
        exp_q.delete();
        tx_busy = 1'b1;
        for (int i = 0; i < 17; i++) begin
            b = 8'($urandom);
            write_byte(b);
            if (i < 16) exp_q.push_back(b);
        end
        check("ovf_level", 32'(level),    32'(16));
        check("ovf_set",   32'(overflow), 32'(1));
        ovf_clear = 1'b1;
        write_byte(8'h77);
        check("ovf_clear_vs_drop", 32'(overflow), 32'(1));
        ovf_clear = 1'b0;
        step();
        ovf_clear = 1'b1;
        step();
        ovf_clear = 1'b0;
        check("ovf_cleared", 32'(overflow), 32'(0));
        tx_busy = 1'b0;
        drain("ovf");
        compare_sent("ovf");

        // Timeout retry: first launch ignored, relaunch 9 cycles later
        hold_len = 6;
        sent.delete();
        ignore_next = 1'b1;
        v0 = valid_cnt;
        write_byte(8'h3C);
        for (int i = 0; i < 60 && (valid_cnt - v0) < 2; i++) step();
        check("retry_pulses", 32'(valid_cnt - v0), 32'(2));
        check("retry_gap",    32'(last_valid_cycle - prev_valid_cycle), 32'(9));
        drain("retry");
        exp_q = '{8'h3C, 8'h3C};
        compare_sent("retry");

        // Full queue with a write on the busy-rise (pop) edge
        hold_len = 3;
        sent.delete();
        exp_q.delete();
        tx_busy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            b = 8'($urandom);
            write_byte(b);
            exp_q.push_back(b);
        end
        tx_busy = 1'b0;
        v0 = valid_cnt;
        for (int i = 0; i < 20 && valid_cnt == v0; i++) step();
        check("fp_launched", 32'(valid_cnt - v0), 32'(1));
        step();
        check("fp_busy_up", 32'(tx_busy), 32'(1));
        write_byte(8'hEE);
        exp_q.push_back(8'hEE);
        check("fp_level",    32'(level),    32'(16));
        check("fp_overflow", 32'(overflow), 32'(0));
        drain("fp");
        compare_sent("fp");

        // Reset in the middle of a transfer discards it
        write_byte(8'h5A);
        v0 = valid_cnt;
        for (int i = 0; i < 10 && valid_cnt == v0; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        v0 = valid_cnt;
        for (int i = 0; i < 30; i++) step();
        check("midrst_no_launch", 32'(valid_cnt - v0), 32'(0));

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            hold_len  = int'($urandom_range(1, 6));
            wr_en     = ($urandom_range(0, 99) < 40);
            wr_data   = 8'($urandom);
            ovf_clear = ($urandom_range(0, 15) == 0);
            if (!ignore_next && $urandom_range(0, 63) == 0) ignore_next = 1'b1;
            step();
        end
        wr_en = 1'b0;
        ovf_clear = 1'b0;
        ignore_next = 1'b0;
        drain("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
